// File: rtl/dtrigger_pkg.sv
// rtl/dtrigger_pkg.sv - shared defaults and fill-width helper for dtrigger_pipe
package dtrigger_pkg;

  localparam int DTRIG_WIDTH_DEF = 8;
  localparam int DTRIG_DEPTH_DEF = 4;

  // Counter wide enough to hold 0..depth inclusive.
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dtrigger_stage.sv
// rtl/dtrigger_stage.sv - one pipeline stage: data register plus valid bit
module dtrigger_stage
  import dtrigger_pkg::*;
#(
  parameter int WIDTH = DTRIG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q;
  logic             vld_q;

  // Flush has priority over advance so a cleared cycle never captures input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else if (en_i) begin
      data_q <= data_i;
      vld_q  <= vld_i;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/dtrigger_pipe.sv
// rtl/dtrigger_pipe.sv - DEPTH-stage enabled delay pipe with fill count
// Optional outq_rise/outq_fall edge flags under DTRIGGER_PIPE_EDGE_EN.
module dtrigger_pipe
  import dtrigger_pkg::*;
#(
  parameter int WIDTH = DTRIG_WIDTH_DEF,
  parameter int DEPTH = DTRIG_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             data,
  input  logic                         data_vld,
  output logic [WIDTH-1:0]             outq,
  output logic                         outq_vld,
`ifdef DTRIGGER_PIPE_EDGE_EN
  output logic [WIDTH-1:0]             outq_rise,
  output logic [WIDTH-1:0]             outq_fall,
`endif
  output logic [fill_width(DEPTH)-1:0] fill
);

  localparam int FW = fill_width(DEPTH);

  // st_*_d is the value each stage would load; st_*_q is what it holds.
  logic [WIDTH-1:0] st_data_d [DEPTH];
  logic [WIDTH-1:0] st_data_q [DEPTH];
  logic [DEPTH-1:0] st_vld_d;
  logic [DEPTH-1:0] st_vld_q;

  assign st_data_d[0] = data;
  assign st_vld_d[0]  = data_vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign st_data_d[i] = st_data_q[i-1];
      assign st_vld_d[i]  = st_vld_q[i-1];
    end

    dtrigger_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .clr_i  (clr),
      .data_i (st_data_d[i]),
      .vld_i  (st_vld_d[i]),
      .data_o (st_data_q[i]),
      .vld_o  (st_vld_q[i])
    );
  end

  assign outq     = st_data_q[DEPTH-1];
  assign outq_vld = st_vld_q[DEPTH-1];

  // Track population incrementally: one sample enters and one leaves per advance.
  logic [FW-1:0] fill_q;
  logic [FW-1:0] fill_d;

  always_comb begin
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (en) begin
      if (st_vld_d[0] && !st_vld_q[DEPTH-1]) begin
        fill_d = fill_q + FW'(1);
      end else if (!st_vld_d[0] && st_vld_q[DEPTH-1]) begin
        fill_d = fill_q - FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;

`ifdef DTRIGGER_PIPE_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Compare the sample about to land in the last stage against the one leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else if (en && !clr && st_vld_q[DEPTH-1] && st_vld_d[DEPTH-1]) begin
      rise_q <= st_data_d[DEPTH-1] & ~st_data_q[DEPTH-1];
      fall_q <= ~st_data_d[DEPTH-1] & st_data_q[DEPTH-1];
    end else begin
      rise_q <= '0;
      fall_q <= '0;
    end
  end

  assign outq_rise = rise_q;
  assign outq_fall = fall_q;
`endif

endmodule

// File: tb/tb_dtrigger_pipe.sv
// tb/tb_dtrigger_pipe.sv - directed self-checking bench for dtrigger_pipe (DEPTH 4 and 1)
module tb_dtrigger_pipe;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] data;
  logic       data_vld;

  logic [7:0] outq4;
  logic       vld4;
  logic [2:0] fill4;
  logic [7:0] outq1;
  logic       vld1;
  logic [0:0] fill1;
`ifdef DTRIGGER_PIPE_EDGE_EN
  logic [7:0] rise4, fall4, rise1, fall1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dtrigger_pipe #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .data      (data),
    .data_vld  (data_vld),
    .outq      (outq4),
    .outq_vld  (vld4),
`ifdef DTRIGGER_PIPE_EDGE_EN
    .outq_rise (rise4),
    .outq_fall (fall4),
`endif
    .fill      (fill4)
  );

  dtrigger_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .data      (data),
    .data_vld  (data_vld),
    .outq      (outq1),
    .outq_vld  (vld1),
`ifdef DTRIGGER_PIPE_EDGE_EN
    .outq_rise (rise1),
    .outq_fall (fall1),
`endif
    .fill      (fill1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [7:0] d, input logic v);
    en = e; clr = c; data = d; data_vld = v;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #12;
    check("rst_outq", outq4, 0);
    check("rst_vld", vld4, 0);
    check("rst_fill", fill4, 0);
    check("rst_fill1", fill1, 0);
    rst = 1'b0;
    #1;

    // Streaming 1..6: DEPTH 4 shows 4-edge latency, DEPTH 1 shows 1-edge latency.
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b0, 8'(k), 1'b1);
      step();
      check($sformatf("fill4_e%0d", k), fill4, (k < 4) ? k : 4);
      check($sformatf("vld4_e%0d", k), vld4, (k >= 4) ? 1 : 0);
      if (k >= 4) check($sformatf("outq4_e%0d", k), outq4, k - 3);
      check($sformatf("outq1_e%0d", k), outq1, k);
      check($sformatf("vld1_e%0d", k), vld1, 1);
      check($sformatf("fill1_e%0d", k), fill1, 1);
    end

    // Stall: outputs and fill freeze, incoming data ignored.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 8'h77, 1'b1);
      step();
      check($sformatf("stall_outq_%0d", k), outq4, 3);
      check($sformatf("stall_fill_%0d", k), fill4, 4);
      check($sformatf("stall_outq1_%0d", k), outq1, 6);
    end
    for (int k = 7; k <= 8; k++) begin
      drive(1'b1, 1'b0, 8'(k), 1'b1);
      step();
      check($sformatf("resume_outq_%0d", k), outq4, k - 3);
    end

    // Bubbles drain the pipe; bubble data still travels.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'h55, 1'b0);
      step();
      check($sformatf("bub_fill_%0d", k), fill4, 3 - k);
      check($sformatf("bub_vld_%0d", k), vld4, (k < 3) ? 1 : 0);
      check($sformatf("bub_outq_%0d", k), outq4, (k < 3) ? 6 + k : 8'h55);
    end
    check("bub_fill1", fill1, 0);
    check("bub_outq1", outq1, 8'h55);

    // Clear wins over en; the 0xAA sample is dropped.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + k), 1'b1);
      step();
    end
    check("pre_clr_fill", fill4, 4);
    drive(1'b1, 1'b1, 8'hAA, 1'b1);
    step();
    check("clr_outq", outq4, 0);
    check("clr_vld", vld4, 0);
    check("clr_fill", fill4, 0);
    check("clr_outq1", outq1, 0);
    check("clr_fill1", fill1, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      step();
      check($sformatf("post_clr_outq_%0d", k), outq4, 0);
      check($sformatf("post_clr_fill_%0d", k), fill4, 0);
    end

    // Async reset while full, en held high during reset.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'(8'h21 + k), 1'b1);
      step();
    end
    check("pre_rst_outq", outq4, 8'h21);
    #2;
    rst = 1'b1;
    #1;
    check("arst_outq", outq4, 0);
    check("arst_vld", vld4, 0);
    check("arst_fill", fill4, 0);
    check("arst_vld1", vld1, 0);
    step();
    check("rst_hold_fill", fill4, 0);
    check("rst_hold_vld1", vld1, 0);
    #2;
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h99, 1'b1);
    step();
    check("post_rst_fill", fill4, 1);
    check("post_rst_vld", vld4, 0);
    check("post_rst_outq1", outq1, 8'h99);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      step();
    end
    check("post_rst_outq", outq4, 8'h99);
    check("post_rst_vld4", vld4, 1);
    check("post_rst_fill4", fill4, 1);

`ifdef DTRIGGER_PIPE_EDGE_EN
    // DEPTH 1 pipe: last stage currently holds an invalid sample.
    drive(1'b1, 1'b0, 8'h0F, 1'b1);
    step();
    check("edge_inv_rise", rise1, 0);
    check("edge_inv_fall", fall1, 0);
    drive(1'b1, 1'b0, 8'h3C, 1'b1);
    step();
    check("edge_rise", rise1, 8'h30);
    check("edge_fall", fall1, 8'h03);
    drive(1'b0, 1'b0, 8'hFF, 1'b1);
    step();
    check("edge_pulse_rise", rise1, 0);
    check("edge_pulse_fall", fall1, 0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    drive(1'b1, 1'b0, 8'hFF, 1'b1);
    step();
    check("edge_prev_inv_rise", rise1, 0);
    check("edge_prev_inv_fall", fall1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dtrigger_pipe.md
DTRIGGER_PIPE -- requirements
Module: dtrigger_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  advance: shift all stages when high, hold when low.
REQ-006 SHALL have port clr  input  1  synchronous flush of all stages.
REQ-007 SHALL have port data  input  WIDTH  sample entering stage 0.
REQ-008 SHALL have port data_vld  input  1  qualifies data.
REQ-009 SHALL have port outq  output  WIDTH  content of last stage (DEPTH-1).
REQ-010 SHALL have port outq_vld  output  1  valid bit of last stage.
REQ-011 SHALL have port fill  output  $clog2(DEPTH+1)  count of valid stages.

Function
REQ-012 Each stage SHALL hold a WIDTH data register plus a valid bit.
REQ-013 On en=1, clr=0: stage0 <= {data, data_vld}; stage i <= stage i-1 for i=1..DEPTH-1.
REQ-014 On en=0, clr=0: all stages, fill and outputs SHALL hold.
REQ-015 On clr=1: all data registers and valid bits SHALL go to 0 next edge; clr wins over en; that cycle's data is dropped.
REQ-016 Latency data -> outq SHALL be exactly DEPTH rising edges with en held high; stalls extend it one cycle each.
REQ-017 Invalid samples (data_vld=0) SHALL still shift, carrying data but valid=0 (bubbles preserved).
REQ-018 fill SHALL be registered and equal the number of set valid bits after every edge: +1 if entering valid and exiting invalid, -1 if reverse, unchanged otherwise; never exceeds DEPTH, never wraps.
REQ-019 DEPTH=1 SHALL degenerate to a single enabled D register with valid; fill is 1 bit.
REQ-020 outq/outq_vld SHALL be driven directly from last-stage registers (no combinational path from inputs).

Reset
REQ-021 rst=1 SHALL immediately (asynchronously) force all data registers, valid bits, fill, and (if compiled) edge flags to 0.
REQ-022 Reset asserted mid-stream SHALL discard all in-flight samples; first post-release en edge loads stage0 only.
REQ-023 en and clr SHALL be ignored while rst=1.

Configuration
REQ-024 Macro DTRIGGER_PIPE_EDGE_EN, when defined, SHALL add outputs outq_rise and outq_fall (each WIDTH).
REQ-025 With it: on an en=1, clr=0 edge where both the current and the incoming last-stage samples are valid, outq_rise <= new & ~old and outq_fall <= ~new & old per bit; otherwise both <= 0; flags last one cycle, aligned with the new outq.
REQ-026 Without it: ports and their registers SHALL not exist; remaining behaviour identical.

Structure
REQ-027 Package dtrigger_pkg SHALL hold default WIDTH/DEPTH constants and the fill-width function.
REQ-028 Sub-module dtrigger_stage (WIDTH data + valid, en, clr, async rst) SHALL be instantiated DEPTH times via generate.
REQ-029 fill counter and edge logic SHALL live in the top module.

Verification
REQ-030 WIDTH=8, DEPTH=4, en=1, data_vld=1, data 0x01,0x02,0x03... -> outq=0x01 with outq_vld=1 on 4th edge, then 0x02, 0x03 per edge; fill 1,2,3,4,4.
REQ-031 Fill to 4, en=0 for 3 cycles -> outq, fill frozen; en=1 resumes with no lost or duplicated sample.
REQ-032 Pipe full, data_vld=0 for 4 edges -> fill 3,2,1,0, outq_vld falls after the 4th bubble reaches the end.
REQ-033 clr=1 with en=1 and data=0xAA valid -> next edge all valid=0, outq=0x00, fill=0, 0xAA never appears.
REQ-034 rst pulsed between edges while full -> outq, outq_vld, fill 0 before next edge; DEPTH=1 run shows 1-edge latency.
REQ-035 EDGE_EN: outq sequence 0x0F then 0x3C (both valid) -> outq_rise=0x30, outq_fall=0x03 for one cycle; invalid previous sample -> both 0x00.
